// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-engine state encoding, parity helper and
// elaboration-time parameter legality check, common to the RX and TX blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  // Expected parity bit for up to 9 data bits (zero-extend narrower words).
  function automatic logic par_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // True when the frame parameters describe a supported configuration.
  function automatic bit cfg_legal(input int unsigned cpp, input int unsigned dw,
                                   input int unsigned pen, input int unsigned podd,
                                   input int unsigned sb);
    return (cpp >= 4) && ((cpp % 2) == 0) && (dw >= 5) && (dw <= 9) &&
           (pen <= 1) && (podd <= 1) && ((sb == 1) || (sb == 2));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops resolve metastability before the signal is used.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: parametrised data width, optional parity and
// 1/2 stop bits, false-start rejection, error flags and valid/ready output
// with overrun detection.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned PARITY_EN        = 0,
  parameter int unsigned PARITY_ODD       = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] DW_M1   = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] SB_M1   = BW'(STOP_BITS - 1);

  generate
    if (!cfg_legal(CLOCKS_PER_PULSE, DATA_WIDTH, PARITY_EN, PARITY_ODD, STOP_BITS)) begin : g_bad_cfg
      $error("uart_rx_cfg: illegal frame parameter set");
    end
  endgenerate

  logic                  w_rx_s;

  uart_state_e           r_state,    w_state_nxt;
  logic [CW-1:0]         r_cnt,      w_cnt_nxt;
  logic [BW-1:0]         r_bit,      w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
  logic                  r_perr_int, w_perr_nxt;
  logic                  r_ferr_int, w_ferr_nxt;
  logic                  w_done;
  logic                  w_done_ferr;

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_overrun;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_d    (rx),
    .o_q    (w_rx_s)
  );

  // Frame engine registers: state, bit-period counter, bit counter, shifter, flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_perr_int <= 1'b0;
      r_ferr_int <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_perr_int <= w_perr_nxt;
      r_ferr_int <= w_ferr_nxt;
    end
  end

  // Next-state logic: sample mid-bit, shift data LSB first, evaluate parity and stop bits.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr_int;
    w_ferr_nxt  = r_ferr_int;
    w_done      = 1'b0;
    w_done_ferr = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rx_s) w_state_nxt = ST_START;
      end

      ST_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_bit_nxt   = '0;
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_WIDTH-1:1]};
          if (r_bit == DW_M1) begin
            w_bit_nxt   = '0;
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = (w_rx_s != par_calc(9'(r_shift), (PARITY_ODD != 0)));
          w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt  = '0;
          w_ferr_nxt = r_ferr_int | ~w_rx_s;
          if (r_bit == SB_M1) begin
            w_bit_nxt   = '0;
            w_done      = 1'b1;
            w_done_ferr = r_ferr_int | ~w_rx_s;
            w_state_nxt = w_done_ferr ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      ST_WAIT_HIGH: begin
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Output holding register: load on completion when free, else flag overrun; clear on transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
          r_perr  <= r_perr_int;
          r_ferr  <= w_done_ferr;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule
